// File: rtl/mio_bus_arbiter_pkg.sv
// rtl/mio_bus_arbiter_pkg.sv - shared encodings for the memory/IO bus arbiter
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_RSVD   = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// rtl/mio_bus_arbiter_if.sv - requester and shared-bus signal bundle
interface mio_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              grant_dma;
    logic [1:0]        state_out;

    // master is the arbiter's view; slave is the requesters' and memory's view
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, grant_dma, state_out
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, grant_dma, state_out
    );
endinterface

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// rtl/mio_bus_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import mio_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       any
);

    // on a tie the requester that did not win last time goes first
    assign gnt[0] = req[0] & (~req[1] | (last == OWN_DMA));
    assign gnt[1] = req[1] & (~req[0] | (last == OWN_CPU));
    assign any    = |req;

endmodule

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - shares one fixed-wait-state memory/IO bus between CPU and DMA
module mio_bus_arbiter
    import mio_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  reset,
    mio_bus_if.master bus
);

    localparam int WC_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W  = (WC_EFF > 1) ? $clog2(WC_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WC_EFF - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic [1:0] gnt;
    logic       any;

    rr_arb2 u_rr (
        .req  ({bus.dma_req, bus.cpu_req}),
        .last (last_q),
        .gnt  (gnt),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= OWN_DMA;
            grant_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        grant_q <= gnt[1];
                        last_q  <= gnt[1];
                        cnt_q   <= '0;
                        we_q    <= gnt[1] ? bus.dma_we    : bus.cpu_we;
                        addr_q  <= gnt[1] ? bus.dma_addr  : bus.cpu_addr;
                        wdata_q <= gnt[1] ? bus.dma_wdata : bus.cpu_wdata;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        if (!we_q) begin
                            if (grant_q == OWN_DMA) dma_rdata_q <= bus.mem_rdata;
                            else                    cpu_rdata_q <= bus.mem_rdata;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_en    = (state_q == ST_ACCESS);
    assign bus.mem_we    = (state_q == ST_ACCESS) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_ready = (state_q == ST_DONE) & (grant_q == OWN_CPU);
    assign bus.dma_ready = (state_q == ST_DONE) & (grant_q == OWN_DMA);
    assign bus.grant_dma = grant_q;
    assign bus.state_out = state_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - directed bench for the CPU/DMA bus arbiter
module tb_mio_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mio_bus_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mio_bus_if #(.ADDR_W(32), .DATA_W(32)) b4 ();
    mio_bus_if #(.ADDR_W(32), .DATA_W(32)) b0 ();

    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .reset(reset), .bus(b2));
    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_w4 (.clk(clk), .reset(reset), .bus(b4));
    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(reset), .bus(b0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = 0; b2.cpu_wdata = 0;
        b2.dma_req = 0; b2.dma_we = 0; b2.dma_addr = 0; b2.dma_wdata = 0; b2.mem_rdata = 0;
        b4.cpu_req = 0; b4.cpu_we = 0; b4.cpu_addr = 0; b4.cpu_wdata = 0;
        b4.dma_req = 0; b4.dma_we = 0; b4.dma_addr = 0; b4.dma_wdata = 0; b4.mem_rdata = 0;
        b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
        b0.dma_req = 0; b0.dma_we = 0; b0.dma_addr = 0; b0.dma_wdata = 0; b0.mem_rdata = 0;
        tick(); tick();
        reset = 1'b0;

        chk("rst_state",  32'(b2.state_out), 32'd0);
        chk("rst_mem_en", 32'(b2.mem_en),    32'd0);
        chk("rst_ready",  32'({b2.cpu_ready, b2.dma_ready}), 32'd0);
        chk("rst_grant",  32'(b2.grant_dma), 32'd0);
        chk("rst_addr",   b2.mem_addr,  32'd0);
        chk("rst_rdata",  b2.cpu_rdata, 32'd0);

        // CPU read alone
        b2.cpu_req = 1; b2.cpu_addr = 32'h10; b2.mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_c1_en",    32'(b2.mem_en),    32'd1);
        chk("t1_c1_we",    32'(b2.mem_we),    32'd0);
        chk("t1_c1_addr",  b2.mem_addr,       32'h10);
        chk("t1_c1_state", 32'(b2.state_out), 32'd1);
        b2.cpu_req = 0;
        tick();
        chk("t1_c2_en",    32'(b2.mem_en),    32'd1);
        chk("t1_c2_rdy",   32'(b2.cpu_ready), 32'd0);
        tick();
        chk("t1_c3_rdy",   32'(b2.cpu_ready), 32'd1);
        chk("t1_c3_dma",   32'(b2.dma_ready), 32'd0);
        chk("t1_c3_en",    32'(b2.mem_en),    32'd0);
        chk("t1_c3_state", 32'(b2.state_out), 32'd2);
        chk("t1_c3_rdata", b2.cpu_rdata,      32'hDEADBEEF);
        tick();
        chk("t1_c4_rdy",   32'(b2.cpu_ready), 32'd0);
        chk("t1_c4_state", 32'(b2.state_out), 32'd0);

        // DMA write leaves dma_rdata alone
        b2.dma_req = 1; b2.dma_we = 1; b2.dma_addr = 32'h20; b2.dma_wdata = 32'h12345678;
        b2.mem_rdata = 32'hBAD0BAD0;
        tick();
        chk("t2_c1_we",    32'(b2.mem_we),    32'd1);
        chk("t2_c1_addr",  b2.mem_addr,       32'h20);
        chk("t2_c1_wdata", b2.mem_wdata,      32'h12345678);
        chk("t2_c1_grant", 32'(b2.grant_dma), 32'd1);
        b2.dma_req = 0; b2.dma_we = 0;
        tick();
        chk("t2_c2_we",    32'(b2.mem_we),    32'd1);
        tick();
        chk("t2_c3_we",    32'(b2.mem_we),    32'd0);
        chk("t2_c3_rdy",   32'(b2.dma_ready), 32'd1);
        chk("t2_c3_crdy",  32'(b2.cpu_ready), 32'd0);
        chk("t2_c3_rdata", b2.dma_rdata,      32'd0);
        tick();
        chk("t2_c4_state", 32'(b2.state_out), 32'd0);

        // both held after reset: CPU, DMA, CPU, DMA
        reset = 1'b1; tick(); reset = 1'b0;
        b2.cpu_req = 1; b2.dma_req = 1; b2.cpu_addr = 32'h30; b2.dma_addr = 32'h34;
        for (int k = 0; k < 4; k++) begin
            b2.mem_rdata = 32'h100 + 32'(k);
            tick();
            chk("t3_grant", 32'(b2.grant_dma), 32'(k % 2));
            chk("t3_addr",  b2.mem_addr, (k % 2 == 0) ? 32'h30 : 32'h34);
            tick(); tick();
            chk("t3_crdy",  32'(b2.cpu_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_drdy",  32'(b2.dma_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("t3_rdata", (k % 2 == 0) ? b2.cpu_rdata : b2.dma_rdata, 32'h100 + 32'(k));
            tick();
            chk("t3_idle",  32'(b2.state_out), 32'd0);
        end
        b2.cpu_req = 0; b2.dma_req = 0;

        // CPU drops request during ACCESS
        b2.cpu_req = 1; b2.cpu_addr = 32'h40; b2.mem_rdata = 32'hCAFE0004;
        tick();
        chk("t4_c1_state", 32'(b2.state_out), 32'd1);
        b2.cpu_req = 0;
        tick(); tick();
        chk("t4_c3_rdy",   32'(b2.cpu_ready), 32'd1);
        chk("t4_c3_rdata", b2.cpu_rdata,      32'hCAFE0004);
        tick();
        chk("t4_c4_state", 32'(b2.state_out), 32'd0);
        tick();
        chk("t4_c5_state", 32'(b2.state_out), 32'd0);

        // reset in second ACCESS cycle of a DMA read
        b2.dma_req = 1; b2.dma_we = 0; b2.dma_addr = 32'h50; b2.mem_rdata = 32'h55AA55AA;
        tick(); tick();
        chk("t5_acc2", 32'(b2.state_out), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_state", 32'(b2.state_out), 32'd0);
        chk("t5_en",    32'(b2.mem_en),    32'd0);
        chk("t5_drdy",  32'(b2.dma_ready), 32'd0);
        chk("t5_rdata", b2.dma_rdata,      32'd0);
        b2.cpu_req = 1; b2.cpu_addr = 32'h58;
        tick();
        chk("t5_grant", 32'(b2.grant_dma), 32'd0);
        chk("t5_addr",  b2.mem_addr,       32'h58);
        b2.cpu_req = 0; b2.dma_req = 0;
        tick(); tick();
        chk("t5_crdy",  32'(b2.cpu_ready), 32'd1);
        tick();

        // WAIT_CYCLES = 4
        b4.cpu_req = 1; b4.cpu_addr = 32'h60; b4.mem_rdata = 32'hA5A50004;
        for (int c = 1; c <= 4; c++) begin
            tick();
            b4.cpu_req = 0;
            chk("t6_w4_en",  32'(b4.mem_en),    32'd1);
            chk("t6_w4_rdy", 32'(b4.cpu_ready), 32'd0);
        end
        tick();
        chk("t6_w4_c5_rdy",   32'(b4.cpu_ready), 32'd1);
        chk("t6_w4_c5_en",    32'(b4.mem_en),    32'd0);
        chk("t6_w4_c5_rdata", b4.cpu_rdata,      32'hA5A50004);
        tick();
        chk("t6_w4_c6_state", 32'(b4.state_out), 32'd0);

        // WAIT_CYCLES = 0 behaves as 1
        b0.cpu_req = 1; b0.cpu_addr = 32'h70; b0.mem_rdata = 32'h0F0F0001;
        tick();
        b0.cpu_req = 0;
        chk("t6_w0_c1_en",    32'(b0.mem_en),    32'd1);
        tick();
        chk("t6_w0_c2_rdy",   32'(b0.cpu_ready), 32'd1);
        chk("t6_w0_c2_en",    32'(b0.mem_en),    32'd0);
        chk("t6_w0_c2_rdata", b0.cpu_rdata,      32'h0F0F0001);
        tick();
        chk("t6_w0_c3_state", 32'(b0.state_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
